// File: rtl/ad9361_rx_pack.sv
// AD9361 receive packer: sign-extends 12-bit I/Q, packs 64-bit words, FWFT FIFO, fixed-length AXI-Stream packets.
// One-cycle push-to-tvalid latency; words arriving at a full FIFO with no pop are dropped and counted.
module ad9361_rx_pack #(
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chan_mode,
    input  logic                          capture_en,
    input  logic                          clr_status,
    input  logic                          adc_d1q1_valid,
    input  logic                          adc_d2q2_valid,
    input  logic [11:0]                   adc_data_d1,
    input  logic [11:0]                   adc_data_q1,
    input  logic [11:0]                   adc_data_d2,
    input  logic [11:0]                   adc_data_q2,
    output logic [63:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic                          misalign,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     LAST_BEAT = 16'(PKT_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t          r_state;
    logic            r_mode;
    logic            r_half_vld;
    logic [31:0]     r_half_dat;
    logic [15:0]     r_beat;
    logic [64:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_overflow;
    logic            r_misalign;
    logic [15:0]     r_drop_cnt;

    logic            w_word_vld;
    logic [63:0]     w_word_dat;
    logic            w_half_set;
    logic            w_half_clr;
    logic            w_misal;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic            w_last;
    logic [15:0]     w_beat_nxt;
    logic            w_half_nxt;
    logic [64:0]     w_rd_word;

    function automatic logic [15:0] sext(input logic [11:0] s);
        return {{4{s[11]}}, s};
    endfunction

    always_comb begin
        w_word_vld = 1'b0;
        w_word_dat = '0;
        w_half_set = 1'b0;
        w_half_clr = 1'b0;
        w_misal    = 1'b0;
        if (r_state != S_IDLE) begin
            if (r_mode) begin
                if (adc_d1q1_valid && adc_d2q2_valid) begin
                    w_word_vld = 1'b1;
                    w_word_dat = {sext(adc_data_q2), sext(adc_data_d2),
                                  sext(adc_data_q1), sext(adc_data_d1)};
                end else if (adc_d1q1_valid ^ adc_d2q2_valid) begin
                    w_misal = 1'b1;
                end
            end else if (adc_d1q1_valid) begin
                if (r_half_vld) begin
                    w_word_vld = 1'b1;
                    w_word_dat = {sext(adc_data_q1), sext(adc_data_d1), r_half_dat};
                    w_half_clr = 1'b1;
                end else begin
                    w_half_set = 1'b1;
                end
            end
        end
    end

    assign w_full     = (r_level == DEPTH_L);
    assign w_pop      = (r_level != '0) && m_axis_tready;
    assign w_wr       = w_word_vld && (!w_full || w_pop);
    assign w_drop     = w_word_vld && w_full && !w_pop;
    assign w_last     = (r_beat == LAST_BEAT);
    assign w_beat_nxt = w_wr ? (w_last ? 16'd0 : r_beat + 16'd1) : r_beat;
    assign w_half_nxt = w_half_set || (r_half_vld && !w_half_clr);

    // Stop decision looks at post-cycle beat/half state so a word formed this cycle is never orphaned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_half_vld <= 1'b0;
            r_half_dat <= '0;
            r_beat     <= '0;
        end else begin
            r_beat <= w_beat_nxt;
            if (w_half_set) begin
                r_half_dat <= {sext(adc_data_q1), sext(adc_data_d1)};
            end
            case (r_state)
                S_IDLE: begin
                    r_half_vld <= 1'b0;
                    if (capture_en) begin
                        r_mode  <= chan_mode;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_half_vld <= w_half_nxt;
                    if (!capture_en) begin
                        r_state <= (w_beat_nxt == 16'd0 && !w_half_nxt) ? S_IDLE : S_STOP;
                    end
                end
                S_STOP: begin
                    r_half_vld <= w_half_nxt;
                    if (w_wr && w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_last, w_word_dat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop coinciding with clr_status leaves the status showing that drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_status) begin
                r_overflow <= 1'b0;
            end
            if (w_misal) begin
                r_misalign <= 1'b1;
            end else if (clr_status) begin
                r_misalign <= 1'b0;
            end
            if (clr_status) begin
                r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
            end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign w_rd_word     = r_mem[r_rd_ptr];
    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? w_rd_word[63:0] : 64'd0;
    assign m_axis_tlast  = m_axis_tvalid && w_rd_word[64];
    assign overflow      = r_overflow;
    assign misalign      = r_misalign;
    assign drop_cnt      = r_drop_cnt;
    assign fifo_level    = r_level;
    assign busy          = (r_state != S_IDLE);
endmodule

// File: doc/ad9361_rx_pack.md
Name: ad9361_rx_pack

Overview:
- Sits directly downstream of the AD9361 PHY receive path in the data_clk domain.
- Takes the per-channel 12-bit I/Q ADC samples and their valid strobes.
- Sign-extends each sample to 16 bits and packs them into 64-bit words.
- Buffers the words in a first-word-fall-through FIFO and presents them as a fixed-length AXI-Stream packet with tlast.
- Overflow is detected, dropped words are counted, and capture starts and stops on packet boundaries.

Parameters:
FIFO_DEPTH, 16, output FIFO depth in 64-bit words; must be a power of 2 and ≥ 4
PKT_LEN, 256, words per packet; tlast asserted on word PKT_LEN-1; range 2..65535

Ports:
clk  in  1  data clock (PHY data_clk); all logic single-clock
rst_n  in  1  asynchronous active-low reset
chan_mode  in  1  0 = channel 1 only, 1 = channels 1 and 2; sampled only in IDLE
capture_en  in  1  level; 1 = capture, 0 = stop at the next packet boundary
clr_status  in  1  one-cycle pulse; clears overflow, misalign and drop_cnt
adc_d1q1_valid  in  1  channel 1 sample strobe
adc_d2q2_valid  in  1  channel 2 sample strobe
adc_data_d1  in  12  channel 1 I, two's complement
adc_data_q1  in  12  channel 1 Q
adc_data_d2  in  12  channel 2 I
adc_data_q2  in  12  channel 2 Q
m_axis_tdata  out  64  packed word
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last word of packet
overflow  out  1  sticky: at least one word was dropped
misalign  out  1  sticky: in dual mode, exactly one of the two strobes was high in a cycle
drop_cnt  out  16  count of dropped words, saturates at 16'hFFFF
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; beat counter 0; half-word register invalid.
- Sign extension: s16 = {{4{s[11]}}, s[11:0]}.
- Word formation, dual mode (mode_r=1):
  - A word is formed on a cycle where both strobes are high.
  - Word = {q2, d2, q1, d1}, with d1 in bits [15:0].
  - A cycle with exactly one strobe high forms no word and sets misalign.
- Word formation, single mode (mode_r=0):
  - adc_d2q2_valid is ignored.
  - The first adc_d1q1_valid sample is stored as the half word.
  - The second sample completes word {q1_b, d1_b, q1_a, d1_a}, with sample a in [31:0].
  - Completing a word clears the half word.
- State machine:
  - IDLE: input samples are discarded; the half word is invalid. When capture_en=1, latch mode_r ← chan_mode and go to RUN on the next cycle.
  - RUN: form words. When capture_en=0:
    - If beat counter = 0 and no half word is valid, go to IDLE.
    - Otherwise go to STOP.
  - STOP: keep forming words until the word with tlast is written to the FIFO, then go to IDLE. capture_en returning to 1 in STOP has no effect; re-arm happens through IDLE.
- Push:
  - A formed word is written with tlast = (beat counter == PKT_LEN-1).
  - The beat counter advances on a write only; it wraps to 0 after PKT_LEN-1.
  - Dropped words do not advance it, so every packet contains exactly PKT_LEN words.
- FIFO:
  - First-word-fall-through.
  - m_axis_tvalid = (level != 0).
  - Pop on tvalid & tready.
  - A word written at edge N is visible on m_axis_tdata/tvalid after edge N (1-cycle latency from the sampling edge).
  - tdata and tlast are held stable while tvalid & !tready.
- Full:
  - Push while full with no pop in the same cycle: the word is dropped, overflow ← 1, and drop_cnt increments (saturating).
  - Push while full with a simultaneous pop: both happen, and level is unchanged.
- Empty with simultaneous push: tvalid rises the next cycle. There is no bypass.
- clr_status and a drop in the same cycle: the drop wins (overflow=1, drop_cnt=1).
- Reset mid-operation: the FIFO is flushed, the partial packet is lost, and all state returns to reset values. Status is not retained.
- FIFO pointers wrap modulo FIFO_DEPTH. level is tracked with a separate counter, range 0..FIFO_DEPTH.

Test Plan:
1. Dual mode, tready=1, 256 sample pairs with d1=12'h800, q1=12'h7FF, d2=1, q2=12'hFFF.
   - First word is 64'hFFFF_0001_07FF_F800.
   - tlast appears only on word 256; no overflow.
2. Single mode, ch1 samples (d,q) = (1,2) then (3,4).
   - Word is 64'h0004_0003_0002_0001.
   - A lone third sample is held until a fourth sample arrives.
3. FIFO_DEPTH=16, tready=0, dual mode, 20 valid pairs.
   - fifo_level=16 and drop_cnt=4; overflow=1.
   - Then tready=1 drains 16 words in order, and a clr_status pulse zeroes the status.
4. Full FIFO, tready=1, and a push in the same cycle: level stays 16 and no drop is counted.
5. capture_en dropped after 10 words of a packet.
   - Capture continues to word 256 with tlast, then busy=0.
   - Strobes after that point produce no words.
6. Dual mode, adc_d1q1_valid=1 with adc_d2q2_valid=0 for one cycle: misalign=1 and no word is written. rst_n pulsed low mid-packet clears the FIFO and all outputs.
